// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
package uart_pkg;

    // Widest supported data word; parity helpers work on this width.
    localparam int MAX_DATA_BITS = 9;

    typedef logic [MAX_DATA_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10,
        MARK = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Parity bit for a data word; narrower words are zero-extended, which
    // leaves the XOR unchanged.
    function automatic logic parity_calc(input word_t data, input parity_mode_t mode);
        logic p;
        p = ^data;
        case (mode)
            EVEN:    return p;
            ODD:     return ~p;
            MARK:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_if.sv
// Bus-side handshake, configuration and receive-status signals of the UART.
interface uart_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
);
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 stop2;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_perror;
    logic                 rx_ferror;

    // Register block side: configures, offers words, consumes receive status.
    modport master (
        output baud_div, parity_mode, stop2, tx_data, tx_valid,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_perror, rx_ferror
    );

    // Transceiver side.
    modport slave (
        input  baud_div, parity_mode, stop2, tx_data, tx_valid,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_perror, rx_ferror
    );
endinterface

// File: rtl/uart_tick_gen.sv
// Oversampling tick generator: one tick every baud_div+1 clocks.
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] period;

    assign tick = (count == period);

    // Count up to the latched period, then wrap and pick up the current divisor.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            count  <= '0;
            period <= '0;
        end else if (tick) begin
            count  <= '0;
            period <= baud_div;
        end else begin
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: valid/ready transmitter and 16x-oversampled receiver
// sharing one tick generator.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic  clk,
    input  logic  reset,
    uart_if.slave bus,
    output logic  txd,
    input  logic  rxd
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] OS_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic tick;

    uart_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .baud_div (bus.baud_div),
        .tick     (tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic                 tx_parity_on;
    logic                 tx_stop2;
    logic                 tx_ready_q;
    logic                 tx_busy_q;

    // Frame sequencer: latches the word and settings at acceptance, then
    // walks start, data (LSB first), optional parity and stop bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_shreg     <= '0;
            tx_par       <= 1'b0;
            tx_parity_on <= 1'b0;
            tx_stop2     <= 1'b0;
            tx_ready_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
            txd          <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        tx_state     <= TX_START;
                        tx_cnt       <= '0;
                        tx_shreg     <= bus.tx_data;
                        tx_par       <= parity_calc(word_t'(bus.tx_data),
                                                    parity_mode_t'(bus.parity_mode));
                        tx_parity_on <= (parity_mode_t'(bus.parity_mode) != NONE);
                        tx_stop2     <= bus.stop2;
                        tx_ready_q   <= 1'b0;
                        tx_busy_q    <= 1'b1;
                        txd          <= 1'b0;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (tick) begin
                        if (tx_cnt != OS_LAST) begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end else begin
                            tx_cnt <= '0;
                            case (tx_state)
                                TX_START: begin
                                    tx_state <= TX_DATA;
                                    tx_idx   <= '0;
                                    txd      <= tx_shreg[0];
                                end
                                TX_DATA: begin
                                    if (tx_idx != IDX_LAST) begin
                                        tx_idx   <= tx_idx + 1'b1;
                                        tx_shreg <= tx_shreg >> 1;
                                        txd      <= tx_shreg[1];
                                    end else if (tx_parity_on) begin
                                        tx_state <= TX_PARITY;
                                        txd      <= tx_par;
                                    end else begin
                                        tx_state <= TX_STOP;
                                        tx_idx   <= '0;
                                        txd      <= 1'b1;
                                    end
                                end
                                TX_PARITY: begin
                                    tx_state <= TX_STOP;
                                    tx_idx   <= '0;
                                    txd      <= 1'b1;
                                end
                                TX_STOP: begin
                                    if (tx_stop2 && tx_idx == '0) begin
                                        tx_idx <= IDX_W'(1);
                                    end else begin
                                        tx_state   <= TX_IDLE;
                                        tx_busy_q  <= 1'b0;
                                        tx_ready_q <= 1'b1;
                                    end
                                end
                                default: tx_state <= TX_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_busy  = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           rx_sync;
    logic                 rxs;
    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    parity_mode_t         rx_mode;
    logic                 rx_perr;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perror_q;
    logic                 rx_ferror_q;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: resets to the idle line level so reset release never looks
        // like a start bit.
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rxd};
    end

    assign rxs = rx_sync[1];

    // Frame receiver: start detect with false-start check, mid-bit sampling,
    // status update at the first stop bit, break hold-off on framing error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shreg    <= '0;
            rx_mode     <= NONE;
            rx_perr     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
        end else begin
            // NOTE: default-low here makes rx_valid a single-cycle pulse
            // without tracking when to clear it.
            rx_valid_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (tick && !rxs) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                        rx_mode  <= parity_mode_t'(bus.parity_mode);
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_cnt != OS_HALF) begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end else begin
                            rx_cnt <= '0;
                            rx_idx <= '0;
                            rx_state <= rxs ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rxs) rx_state <= RX_IDLE;
                end
                default: begin
                    if (tick) begin
                        if (rx_cnt != OS_LAST) begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end else begin
                            rx_cnt <= '0;
                            case (rx_state)
                                RX_DATA: begin
                                    rx_shreg <= {rxs, rx_shreg[DATA_BITS-1:1]};
                                    if (rx_idx != IDX_LAST) begin
                                        rx_idx <= rx_idx + 1'b1;
                                    end else begin
                                        rx_perr  <= 1'b0;
                                        rx_state <= (rx_mode == NONE) ? RX_STOP : RX_PARITY;
                                    end
                                end
                                RX_PARITY: begin
                                    rx_perr  <= (rxs != parity_calc(word_t'(rx_shreg), rx_mode));
                                    rx_state <= RX_STOP;
                                end
                                RX_STOP: begin
                                    rx_data_q   <= rx_shreg;
                                    rx_perror_q <= rx_perr;
                                    rx_ferror_q <= !rxs;
                                    rx_valid_q  <= 1'b1;
                                    rx_state    <= rxs ? RX_IDLE : RX_BREAK;
                                end
                                default: rx_state <= RX_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_perror = rx_perror_q;
    assign bus.rx_ferror = rx_ferror_q;

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART for the serial-link subsystem. It generalises the fixed 8-data-bit, even-parity pair to configurable data width, a runtime baud divisor, selectable parity mode and one or two stop bits. It adds a valid/ready transmit handshake and a 16x-oversampled, mid-bit-sampling receiver with a false-start filter. It sits between the bus-side register block and the pads (`txd`, `rxd`).

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and ≥ 8.
- `DIV_W`, default 16: width of the baud divisor.

Ports:
- `clk`  in  1  single clock; all logic is in this domain.
- `reset`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_W  sample tick period in clocks, equal to `baud_div`+1.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- `stop2`  in  1  1 selects two stop bits on transmit.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  transmitter can accept a word.
- `txd`  out  1  serial output; idles high.
- `tx_busy`  out  1  a frame is in progress.
- `rxd`  in  1  asynchronous serial input.
- `rx_data`  out  DATA_BITS  last received word.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `rx_perror`  out  1  parity mismatch on the last frame.
- `rx_ferror`  out  1  first stop bit sampled low on the last frame.

## Operation
- **Tick generator**
  - Free-running counter 0..`baud_div`; `tick` is high for one cycle at `baud_div`, then the counter wraps.
  - A changed `baud_div` takes effect at the next wrap.
  - When `baud_div` = 0, `tick` is high every cycle.
- **Transmitter FSM**: IDLE → START → DATA → PARITY → STOP.
  - PARITY is skipped when `parity_mode` = 00.
  - `tx_ready` = (state == IDLE) and not in reset.
  - A word is accepted on a clock with `tx_valid` && `tx_ready`. At acceptance the block latches `tx_data`, `parity_mode` and `stop2`; changes to these inputs mid-frame have no effect.
  - Each bit lasts OVERSAMPLE ticks. Data is sent LSB first.
  - Parity bit: even = XOR of the data; odd = its inverse; mark = 1.
  - Stop field is 1 or 2 bit-times high.
  - `tx_busy` is high from the cycle after acceptance until the end of the stop field.
- **Receiver**
  - `rxd` passes through a 2-flop synchroniser that resets to 1. All checks below use the synchronised value.
  - IDLE: on a tick with `rxd` low, go to START and clear the tick count.
  - START: at tick OVERSAMPLE/2−1, re-sample `rxd`. If high, the start is false; return to IDLE with no output change.
  - DATA: sample at each bit centre, every OVERSAMPLE ticks; shift in LSB first.
  - PARITY (when enabled): compare the sampled bit with the value computed using the `parity_mode` latched at start detection.
  - STOP: sample the first stop bit at its centre. In that same cycle, update `rx_data`, `rx_perror` and `rx_ferror`, and pulse `rx_valid`. These outputs hold until the next frame completes.
  - Stop sampled high: go to IDLE immediately, so back-to-back frames are accepted.
  - Stop sampled low: go to BREAK, which waits for `rxd` high before returning to IDLE.
  - Only one stop bit is checked on receive, regardless of `stop2`.

## Timing
- Reset values:
  - `txd` = 1, `tx_busy` = 0.
  - `tx_ready` = 0 while `reset` is low, 1 from the first clock after release.
  - `rx_data` = 0, `rx_valid` = 0, `rx_perror` = 0, `rx_ferror` = 0.
  - Both FSMs in IDLE; tick counter = 0.
- TX latency: `txd` falls the cycle after acceptance.
- TX start-bit length: between (OVERSAMPLE−1)·(`baud_div`+1)+1 and OVERSAMPLE·(`baud_div`+1) clocks. All later bits are exactly OVERSAMPLE·(`baud_div`+1) clocks.
- `tx_ready` rises the cycle after the final stop bit ends, so back-to-back frames have no extra idle gap.
- RX: `rx_valid` fires 2 synchroniser clocks plus (1 + DATA_BITS + P + 0.5) bit-times after the falling edge, ±1 tick. P = 1 if parity is enabled, else 0.
- Reset mid-frame: both FSMs abort asynchronously and `txd` returns high immediately. No `rx_valid` is produced for the interrupted frame.
- Simultaneous TX and RX activity is independent. The only shared resource is the tick.

## Structure
- Package `uart_pkg`:
  - `parity_mode_t` enum (NONE, EVEN, ODD, MARK).
  - `tx_state_t` and `rx_state_t` enums.
  - `parity_calc` function (data, mode → bit).
- Sub-module `uart_tick_gen`: divisor counter producing `tick`. `uart_transceiver` instantiates it once, shared by TX and RX.

## Test plan
1. DATA_BITS=8, `baud_div`=3, even parity, send 0xA5 → `txd` shows 0,1,0,1,0,0,1,0,1,0,1; each bit is 64 clocks; `tx_ready` is low throughout.
2. Loopback `txd`→`rxd`, odd parity, `stop2`=1, send 0x0F then 0xF0 back-to-back → two `rx_valid` pulses with 0x0F and 0xF0; `rx_perror` = `rx_ferror` = 0; the stop field is 128 clocks.
3. Drive `rxd` low for 5 ticks, then high → no `rx_valid`; the receiver is back in IDLE and accepts a following valid frame.
4. Inject a frame with a flipped parity bit, then one with stop = 0 → first frame gives `rx_valid` with `rx_perror`=1. Second gives `rx_valid` with `rx_ferror`=1; a later frame starting before `rxd` returns high is ignored.
5. Assert `reset` low mid-data during TX → `txd`=1 and `tx_busy`=0 immediately; after release, `tx_ready`=1 and a fresh 0x3C transmits correctly.
